axi_mem_arbiter: RTL and testbench

- Shares the single 128-bit AXI4 master port to DDR between two requesters: port 0 is the data cache (refill and write-back), port 1 is the instruction memory loader.
- Each granted request becomes one single-beat AXI transaction: a read (AR then R) or a write (AW plus W then B).
- Result data and status return to the requester with a one-cycle acknowledge.
- Sits between the cache controllers and the top-level M_AXI_* pins.

---
 rtl/axi_mem_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter that turns cache and loader requests into single-beat AXI4
// transactions on one shared master port, with a per-state watchdog.
module axi_mem_arbiter #(
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     addr0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     addr1,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWLOCK,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic [2:0]            M_AXI_AWPROT,
    output logic [3:0]            M_AXI_AWQOS,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic                  M_AXI_BVALID,
    input  logic [1:0]            M_AXI_BRESP,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [7:0]            M_AXI_ARLEN,
    output logic [2:0]            M_AXI_ARSIZE,
    output logic [1:0]            M_AXI_ARBURST,
    output logic                  M_AXI_ARLOCK,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic [2:0]            M_AXI_ARPROT,
    output logic [3:0]            M_AXI_ARQOS,
    input  logic                  M_AXI_RVALID,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RLAST,
    output logic                  M_AXI_RREADY
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(15);

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWrite, StWresp, StDone} state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_port;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_ack0;
    logic                r_ack1;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_aw_sent;
    logic                r_w_sent;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_gnt;
    logic                w_gnt_we;
    logic                w_aw_ok;
    logic                w_w_ok;
    logic                w_wait;
    logic                w_tmo;

    // On a tie, the port that did not win last time gets the grant.
    assign w_gnt    = (req0 & req1) ? ~r_last : req1;
    assign w_gnt_we = w_gnt ? we1 : we0;
    assign w_aw_ok  = r_aw_sent | (r_awvalid & M_AXI_AWREADY);
    assign w_w_ok   = r_w_sent | (r_wvalid & M_AXI_WREADY);
    assign w_wait   = (r_state == StRaddr) | (r_state == StRdata) |
                      (r_state == StWrite) | (r_state == StWresp);
    assign w_tmo    = w_wait & (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_last    <= 1'b1;
            r_port    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_cnt  <= r_cnt + 1'b1;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (req0 | req1) begin
                        r_port  <= w_gnt;
                        r_last  <= w_gnt;
                        r_addr  <= (w_gnt ? addr1 : addr0) & ADDR_MASK;
                        r_wdata <= w_gnt ? wdata1 : wdata0;
                        if (w_gnt_we) begin
                            r_state   <= StWrite;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_sent <= 1'b0;
                            r_w_sent  <= 1'b0;
                        end else begin
                            r_state   <= StRaddr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                StRaddr: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= StRdata;
                    end
                end
                StRdata: begin
                    if (M_AXI_RVALID) begin
                        r_rdata  <= M_AXI_RDATA;
                        r_err    <= (M_AXI_RRESP != 2'b00) | ~M_AXI_RLAST;
                        r_rready <= 1'b0;
                        r_ack0   <= ~r_port;
                        r_ack1   <= r_port;
                        r_state  <= StDone;
                    end
                end
                StWrite: begin
                    if (r_awvalid & M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_aw_sent <= 1'b1;
                    end
                    if (r_wvalid & M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                        r_w_sent <= 1'b1;
                    end
                    if (w_aw_ok & w_w_ok) begin
                        r_bready <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= StWresp;
                    end
                end
                StWresp: begin
                    if (M_AXI_BVALID) begin
                        r_err    <= (M_AXI_BRESP != 2'b00);
                        r_bready <= 1'b0;
                        r_ack0   <= ~r_port;
                        r_ack1   <= r_port;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
            // Watchdog wins over any handshake landing on the same cycle; the slave is
            // presumed broken, so the transaction is abandoned rather than retried.
            if (w_tmo) begin
                r_state   <= StDone;
                r_err     <= 1'b1;
                r_rdata   <= r_rdata;
                r_ack0    <= ~r_port;
                r_ack1    <= r_port;
                r_arvalid <= 1'b0;
                r_rready  <= 1'b0;
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_bready  <= 1'b0;
            end
        end
    end

    assign ack0  = r_ack0;
    assign ack1  = r_ack1;
    assign rdata = r_rdata;
    assign err   = r_err;
    assign busy  = (r_state != StIdle);

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b100;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b100;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'd0;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: vector table on a well-behaved slave plus
// hand-written sequences for stalls, round-robin, timeout and mid-transaction reset.
module tb_axi_mem_arbiter;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned TMO    = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0, we0, req1, we1;
    logic [ADDR_W-1:0]   addr0, addr1;
    logic [DATA_W-1:0]   wdata0, wdata1;
    logic                ack0, ack1, err, busy;
    logic [DATA_W-1:0]   rdata;
    logic [ADDR_W-1:0]   M_AXI_AWADDR, M_AXI_ARADDR;
    logic                M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_AWLOCK, M_AXI_ARLOCK;
    logic [7:0]          M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]          M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
    logic [1:0]          M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic [3:0]          M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS;
    logic [DATA_W-1:0]   M_AXI_WDATA, M_AXI_RDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic                M_AXI_BVALID, M_AXI_BREADY;
    logic                M_AXI_ARVALID, M_AXI_ARREADY;
    logic                M_AXI_RVALID, M_AXI_RLAST, M_AXI_RREADY;

    always #5 clk = ~clk;

    axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
        .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        string             name;
        logic              port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] sdata;
        logic [1:0]        resp;
        logic              rlast;
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_err;
    } vec_t;

    vec_t              vecs[7];
    vec_t              vpost;
    vec_t              vslow;
    int                checks   = 0;
    int                failures = 0;
    logic [DATA_W-1:0] m_rdata;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic port, input logic on, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (port) begin
            req1 = on; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = on; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    // Slave grants AR/W immediately, AW after aw_delay extra cycles, and answers R/B
    // one cycle after it first sees RREADY/BREADY.
    task automatic run_txn(input vec_t v, input int aw_delay);
        int   aw_cnt, w_cnt, ar_cnt, rr_cnt, br_cnt, br_first, ack_n;
        logic got;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rr_cnt = 0; br_cnt = 0; br_first = 0;
        ack_n = 0; got = 1'b0;
        M_AXI_ARREADY = 1'b1;
        M_AXI_WREADY  = 1'b1;
        M_AXI_AWREADY = (aw_delay == 0);
        M_AXI_RVALID  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_RDATA   = v.sdata;
        M_AXI_RRESP   = v.resp;
        M_AXI_RLAST   = v.rlast;
        M_AXI_BRESP   = v.resp;
        set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (M_AXI_ARVALID) begin
                ar_cnt++;
                chk({v.name, " araddr"}, M_AXI_ARADDR, v.exp_addr);
            end
            if (M_AXI_AWVALID) begin
                aw_cnt++;
                if (M_AXI_AWREADY) chk({v.name, " awaddr"}, M_AXI_AWADDR, v.exp_addr);
            end
            if (M_AXI_WVALID) begin
                w_cnt++;
                chk({v.name, " wdata"}, M_AXI_WDATA, v.wdata);
            end
            if (aw_cnt == aw_delay + 1) M_AXI_AWREADY = 1'b1;
            if (M_AXI_BREADY && br_first == 0) br_first = n;
            rr_cnt = M_AXI_RREADY ? rr_cnt + 1 : 0;
            br_cnt = M_AXI_BREADY ? br_cnt + 1 : 0;
            M_AXI_RVALID = (rr_cnt == 2);
            M_AXI_BVALID = (br_cnt == 2);
            if (ack0 | ack1) begin
                got   = 1'b1;
                ack_n = n;
                chk({v.name, " ack port"}, {ack1, ack0}, v.port ? 2'b10 : 2'b01);
                chk({v.name, " err"}, err, v.exp_err);
                if (!v.we) m_rdata = v.sdata;
                chk({v.name, " rdata"}, rdata, m_rdata);
                set_req(v.port, 1'b0, v.we, v.addr, v.wdata);
            end
        end
        chk({v.name, " ack seen"}, got, 1'b1);
        if (v.we) begin
            chk({v.name, " ack latency"}, ack_n, aw_delay + 4);
            chk({v.name, " awvalid cycles"}, aw_cnt, aw_delay + 1);
            chk({v.name, " wvalid cycles"}, w_cnt, 1);
            chk({v.name, " first bready"}, br_first, aw_delay + 2);
        end else begin
            chk({v.name, " ack latency"}, ack_n, 4);
            chk({v.name, " arvalid cycles"}, ar_cnt, 1);
        end
        @(negedge clk);
        chk({v.name, " single ack"}, {ack1, ack0}, 2'b00);
        chk({v.name, " idle after"}, busy, 1'b0);
        M_AXI_RVALID  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_AWREADY = 1'b1;
    endtask

    initial begin
        int   k, rr_cnt, arv, ack_n;
        logic got;
        vecs[0] = '{"rd0", 1'b0, 1'b0, 27'h0000123, 128'h0,
                    128'hDEADBEEF_00000000_00000000_00000001, 2'b00, 1'b1, 27'h0000120, 1'b0};
        vecs[1] = '{"rd1", 1'b1, 1'b0, 27'h7FFFFFF, 128'h0,
                    128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 2'b00, 1'b1, 27'h7FFFFF0, 1'b0};
        vecs[2] = '{"rd0_slverr", 1'b0, 1'b0, 27'h0004567, 128'h0,
                    128'h11112222_33334444_55556666_77778888, 2'b10, 1'b1, 27'h0004560, 1'b1};
        vecs[3] = '{"rd1_nolast", 1'b1, 1'b0, 27'h000ABCF, 128'h0,
                    128'h99, 2'b00, 1'b0, 27'h000ABC0, 1'b1};
        vecs[4] = '{"wr0", 1'b0, 1'b1, 27'h0ABCDEF,
                    128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h0, 2'b00, 1'b1,
                    27'h0ABCDE0, 1'b0};
        vecs[5] = '{"wr1_decerr", 1'b1, 1'b1, 27'h1000011, 128'hCAFE, 128'h0, 2'b11, 1'b1,
                    27'h1000010, 1'b1};
        vecs[6] = '{"wr1", 1'b1, 1'b1, 27'h3333339, 128'h5555_AAAA, 128'h0, 2'b00, 1'b1,
                    27'h3333330, 1'b0};
        vslow   = '{"wr1_awslow", 1'b1, 1'b1, 27'h2000008, 128'hBEEF_0001, 128'h0, 2'b00, 1'b1,
                    27'h2000000, 1'b0};
        vpost   = '{"rd0_postrst", 1'b0, 1'b0, 27'h0000777, 128'h0, 128'h7777_0000_1111,
                    2'b00, 1'b1, 27'h0000770, 1'b0};

        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b1;
        m_rdata = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset handshakes", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
            M_AXI_RREADY, ack0, ack1, err, busy}, 9'd0);
        chk("reset rdata", rdata, 128'h0);
        chk("axi constants", {M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
            M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_ARLEN, M_AXI_ARSIZE,
            M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS,
            M_AXI_WLAST}, {8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0,
            8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b1});
        chk("wstrb", M_AXI_WSTRB, 16'hFFFF);
        rst = 1'b1;

        // Both ports held high straight out of reset: expect 0,1,0,1.
        M_AXI_ARREADY = 1'b1; M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 27'h0000400, '0);
        set_req(1'b1, 1'b1, 1'b0, 27'h0000800, '0);
        k = 0; rr_cnt = 0;
        for (int n = 0; n < 80 && k < 4; n++) begin
            @(negedge clk);
            if (M_AXI_ARVALID) M_AXI_RDATA = DATA_W'(M_AXI_ARADDR) + 1;
            rr_cnt = M_AXI_RREADY ? rr_cnt + 1 : 0;
            M_AXI_RVALID = (rr_cnt == 2);
            if (ack0 | ack1) begin
                chk($sformatf("rr ack #%0d port", k), {ack1, ack0}, (k % 2) ? 2'b10 : 2'b01);
                chk($sformatf("rr ack #%0d rdata", k), rdata, (k % 2) ? 128'h801 : 128'h401);
                k++;
                if (k == 4) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        chk("rr ack count", k, 4);
        M_AXI_RVALID = 1'b0;
        m_rdata = 128'h801;
        repeat (2) @(negedge clk);
        chk("rr idle after", busy, 1'b0);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], 0);
        run_txn(vslow, 3);

        // ARREADY never comes: watchdog must end the read with an error.
        M_AXI_ARREADY = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 27'h0001230, '0);
        arv = 0; got = 1'b0; ack_n = 0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (M_AXI_ARVALID) arv++;
            if (ack0 | ack1) begin
                got = 1'b1;
                ack_n = n;
                chk("tmo ack port", {ack1, ack0}, 2'b01);
                chk("tmo err", err, 1'b1);
                chk("tmo rdata held", rdata, m_rdata);
                chk("tmo arvalid dropped", M_AXI_ARVALID, 1'b0);
                req0 = 1'b0;
            end
        end
        chk("tmo ack seen", got, 1'b1);
        chk("tmo arvalid cycles", arv, TMO);
        chk("tmo ack cycle", ack_n, TMO + 1);
        @(negedge clk);
        chk("tmo busy after", busy, 1'b0);
        M_AXI_ARREADY = 1'b1;

        // Reset while waiting for B.
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 27'h0000050, 128'h1234);
        got = 1'b0;
        for (int n = 1; n <= 10 && !got; n++) begin
            @(negedge clk);
            if (M_AXI_BREADY) got = 1'b1;
        end
        chk("reach wresp", got, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async rst handshakes", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
            M_AXI_ARVALID, M_AXI_RREADY, ack0, ack1, err, busy}, 9'd0);
        chk("async rst rdata", rdata, 128'h0);
        m_rdata = '0;
        req0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_txn(vpost, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
